// File: rtl/game_tick_scheduler.sv
// game_tick_scheduler
// Central timing controller for the game logic. Produces single-cycle clock
// enables (not divided clocks) in the clk_25MHz domain:
//   bullet_tick - every BULLET_PERIOD running cycles
//   march_tick  - every march_period running cycles (shortened by speed-ups)
//   sec_tick    - every CLK_HZ running cycles
// A run/pause/over state machine gates all ticks.
//
// Ports:
//   clk_25MHz     in   system clock
//   reset_n       in   asynchronous active-low reset
//   start         in   level, begins a new game from IDLE/OVER
//   pause         in   level, freezes all timing while high
//   game_over     in   level, ends the game (highest priority)
//   speed_up_req  in   single-cycle request to shorten the march period
//   speed_up_ack  out  single-cycle acknowledge, one cycle after acceptance
//   march_tick    out  alien-march enable
//   bullet_tick   out  bullet-motion enable
//   sec_tick      out  one-second enable
//   running       out  high while the game is in RUN
//   march_period  out  current march period in cycles
module game_tick_scheduler #(
  parameter int CLK_HZ        = 25000000,
  parameter int BULLET_PERIOD = 250000,
  parameter int MARCH_BASE    = 12500000,
  parameter int MARCH_MIN     = 1250000,
  parameter int MARCH_STEP    = 250000,
  parameter int CNT_W         = 25
) (
  input  logic             clk_25MHz,
  input  logic             reset_n,
  input  logic             start,
  input  logic             pause,
  input  logic             game_over,
  input  logic             speed_up_req,
  output logic             speed_up_ack,
  output logic             march_tick,
  output logic             bullet_tick,
  output logic             sec_tick,
  output logic             running,
  output logic [CNT_W-1:0] march_period
);

  localparam logic [CNT_W-1:0] SEC_P    = CNT_W'(CLK_HZ);
  localparam logic [CNT_W-1:0] BULLET_P = CNT_W'(BULLET_PERIOD);
  localparam logic [CNT_W-1:0] BASE_P   = CNT_W'(MARCH_BASE);
  localparam logic [CNT_W-1:0] MIN_P    = CNT_W'(MARCH_MIN);
  localparam logic [CNT_W-1:0] STEP_P   = CNT_W'(MARCH_STEP);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  // Smallest period from which a full step can be taken without going below
  // the floor; one bit wider so the sum cannot overflow.
  localparam logic [CNT_W:0]   SAT_THRESH = (CNT_W+1)'(MARCH_MIN + MARCH_STEP);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_OVER   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] march_period_q, march_period_d;
  logic             ack_q, ack_d;
  logic             running_q, running_d;

  logic             advance;     // counters step on this edge
  logic             start_game;  // entering RUN from IDLE/OVER
  logic             accept;      // speed-up request taken on this edge

  // Next-state logic: game_over > pause > start.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !game_over) state_d = S_RUN;
      end
      S_RUN: begin
        if (game_over)  state_d = S_OVER;
        else if (pause) state_d = S_PAUSED;
      end
      S_PAUSED: begin
        if (game_over)   state_d = S_OVER;
        else if (!pause) state_d = S_RUN;
      end
      S_OVER: begin
        if (start && !game_over) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The resume edge out of PAUSED counts as a running edge, so a tick that
  // was held at P-1 by the pause fires on that very edge.
  always_comb begin
    advance    = (state_q == S_RUN || state_q == S_PAUSED) && (state_d == S_RUN);
    start_game = (state_q == S_IDLE || state_q == S_OVER) && (state_d == S_RUN);
    accept     = (state_q == S_RUN) && (state_d == S_RUN) && speed_up_req;
  end

  // March period: reload on a new game, saturating step-down on a speed-up.
  always_comb begin
    march_period_d = march_period_q;
    ack_d          = accept;
    running_d      = (state_d == S_RUN);
    if (start_game) begin
      march_period_d = BASE_P;
    end else if (accept) begin
      if ({1'b0, march_period_q} >= SAT_THRESH) march_period_d = march_period_q - STEP_P;
      else                                      march_period_d = MIN_P;
    end
  end

  always_ff @(posedge clk_25MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      march_period_q <= BASE_P;
      ack_q          <= 1'b0;
      running_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      march_period_q <= march_period_d;
      ack_q          <= ack_d;
      running_q      <= running_d;
    end
  end

  // Three identical tick channels; channel 0 = bullet, 1 = march, 2 = second.
  logic [CNT_W-1:0] period_w [3];
  logic             tick_w   [3];

  assign period_w[0] = BULLET_P;
  assign period_w[1] = march_period_q;
  assign period_w[2] = SEC_P;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             tick_q, tick_d;

      always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (advance) begin
          // >= rather than == so a period shortened below the current count
          // fires on the next edge instead of wrapping around.
          if (cnt_q >= period_w[gi] - ONE) begin
            cnt_d  = '0;
            tick_d = 1'b1;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end else if (start_game || state_d == S_IDLE || state_d == S_OVER) begin
          cnt_d = '0;
        end
        // Otherwise (entering or staying in PAUSED) the count is frozen, even
        // at P-1, so a suppressed tick is delivered after resume.
      end

      always_ff @(posedge clk_25MHz or negedge reset_n) begin
        if (!reset_n) begin
          cnt_q  <= '0;
          tick_q <= 1'b0;
        end else begin
          cnt_q  <= cnt_d;
          tick_q <= tick_d;
        end
      end

      assign tick_w[gi] = tick_q;
    end
  endgenerate

  assign bullet_tick  = tick_w[0];
  assign march_tick   = tick_w[1];
  assign sec_tick     = tick_w[2];
  assign speed_up_ack = ack_q;
  assign running      = running_q;
  assign march_period = march_period_q;

endmodule
